// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: pops bytes from the TX FIFO and sends start, 8 data bits LSB-first, optional parity, 1/2 stops.
// Optional parity stage is compiled in when UART_TX_PARITY_EN is defined.
module uart_tx_ctrl #(
  parameter int DIV_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             stop2,
  input  logic             tx_en,
  input  logic             tx_fifo_empty,
  input  logic [7:0]       tx_data,
`ifdef UART_TX_PARITY_EN
  input  logic             parity_en,
  input  logic             parity_odd,
`endif
  output logic             tx_fifo_rd_en,
  output logic             tx_serial,
  output logic             tx_busy,
  output logic             tx_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

`ifdef UART_TX_PARITY_EN
  function automatic logic frame_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction
`endif

  state_t           state_r, state_next_s;
  logic [DIV_W-1:0] cnt_r, cnt_next_s;
  logic [DIV_W-1:0] div_r, div_next_s, div_load_s;
  logic [2:0]       bit_cnt_r, bit_cnt_next_s;
  logic [7:0]       shift_r, shift_next_s;
  logic             stop2_r, stop2_next_s;
  logic             serial_r, serial_next_s;
  logic             busy_r, busy_next_s;
  logic             done_r, done_next_s;
  logic             load_s;
  logic             period_end_s;
`ifdef UART_TX_PARITY_EN
  logic             par_en_r, par_en_next_s;
  logic             par_bit_r, par_bit_next_s;
`endif

  // A frame loads only from IDLE; reset also blocks the pop so a reset cycle never consumes a byte.
  assign load_s       = (state_r == S_IDLE) && tx_en && !tx_fifo_empty && !reset;
  assign div_load_s   = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;
  assign period_end_s = (cnt_r == (div_r - DIV_W'(1)));

  assign tx_fifo_rd_en = load_s;
  assign tx_serial     = serial_r;
  assign tx_busy       = busy_r;
  assign tx_done       = done_r;

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= S_IDLE;
      cnt_r     <= {DIV_W{1'b0}};
      div_r     <= DIV_W'(2);
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
      stop2_r   <= 1'b0;
      serial_r  <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_r  <= 1'b0;
      par_bit_r <= 1'b0;
`endif
    end else begin
      state_r   <= state_next_s;
      cnt_r     <= cnt_next_s;
      div_r     <= div_next_s;
      bit_cnt_r <= bit_cnt_next_s;
      shift_r   <= shift_next_s;
      stop2_r   <= stop2_next_s;
      serial_r  <= serial_next_s;
      busy_r    <= busy_next_s;
      done_r    <= done_next_s;
`ifdef UART_TX_PARITY_EN
      par_en_r  <= par_en_next_s;
      par_bit_r <= par_bit_next_s;
`endif
    end
  end

  // Next-state and counter sequencing.
  always_comb begin
    state_next_s   = state_r;
    cnt_next_s     = cnt_r + DIV_W'(1);
    div_next_s     = div_r;
    bit_cnt_next_s = bit_cnt_r;
    shift_next_s   = shift_r;
    stop2_next_s   = stop2_r;
    done_next_s    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_next_s  = par_en_r;
    par_bit_next_s = par_bit_r;
`endif
    case (state_r)
      S_IDLE: begin
        cnt_next_s = {DIV_W{1'b0}};
        if (load_s) begin
          state_next_s   = S_START;
          shift_next_s   = tx_data;
          div_next_s     = div_load_s;
          stop2_next_s   = stop2;
          bit_cnt_next_s = 3'd0;
`ifdef UART_TX_PARITY_EN
          par_en_next_s  = parity_en;
          par_bit_next_s = frame_parity(tx_data, parity_odd);
`endif
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_START: begin
        if (period_end_s) begin
          cnt_next_s   = {DIV_W{1'b0}};
          state_next_s = S_DATA;
        end else begin
          state_next_s = S_START;
        end
      end
      S_DATA: begin
        if (period_end_s) begin
          cnt_next_s   = {DIV_W{1'b0}};
          shift_next_s = {1'b0, shift_r[7:1]};
          if (bit_cnt_r == 3'd7) begin
            bit_cnt_next_s = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_next_s   = par_en_r ? S_PARITY : S_STOP;
`else
            state_next_s   = S_STOP;
`endif
          end else begin
            bit_cnt_next_s = bit_cnt_r + 3'd1;
          end
        end else begin
          state_next_s = S_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (period_end_s) begin
          cnt_next_s   = {DIV_W{1'b0}};
          state_next_s = S_STOP;
        end else begin
          state_next_s = S_PARITY;
        end
      end
`endif
      S_STOP: begin
        // The bit counter doubles as the stop-bit index.
        if (period_end_s) begin
          cnt_next_s = {DIV_W{1'b0}};
          if (stop2_r && (bit_cnt_r == 3'd0)) begin
            bit_cnt_next_s = 3'd1;
          end else begin
            bit_cnt_next_s = 3'd0;
            state_next_s   = S_IDLE;
            done_next_s    = 1'b1;
          end
        end else begin
          state_next_s = S_STOP;
        end
      end
      default: begin
        state_next_s   = S_IDLE;
        cnt_next_s     = {DIV_W{1'b0}};
        bit_cnt_next_s = 3'd0;
      end
    endcase
  end

  // Line level and busy flag for the upcoming state, so both outputs come straight from flops.
  always_comb begin
    serial_next_s = 1'b1;
    busy_next_s   = 1'b1;
    case (state_next_s)
      S_IDLE: begin
        serial_next_s = 1'b1;
        busy_next_s   = 1'b0;
      end
      S_START:  serial_next_s = 1'b0;
      S_DATA:   serial_next_s = shift_next_s[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: serial_next_s = par_bit_next_s;
`endif
      S_STOP:   serial_next_s = 1'b1;
      default: begin
        serial_next_s = 1'b1;
        busy_next_s   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: a FIFO model feeds bytes, expected frames are queued at issue
// and a negedge monitor compares every line level, busy, done and pop against them.
module tb_uart_tx_ctrl;
  localparam int DIV_W = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [DIV_W-1:0] baud_div = 16'd4;
  logic             stop2 = 1'b0;
  logic             tx_en = 1'b0;
  logic             tx_fifo_empty = 1'b1;
  logic [7:0]       tx_data = 8'h00;
`ifdef UART_TX_PARITY_EN
  logic             parity_en = 1'b0;
  logic             parity_odd = 1'b0;
`endif
  logic             tx_fifo_rd_en, tx_serial, tx_busy, tx_done;

  uart_tx_ctrl #(.DIV_W(DIV_W)) dut (
    .clock(clock), .reset(reset), .baud_div(baud_div), .stop2(stop2), .tx_en(tx_en),
    .tx_fifo_empty(tx_fifo_empty), .tx_data(tx_data),
`ifdef UART_TX_PARITY_EN
    .parity_en(parity_en), .parity_odd(parity_odd),
`endif
    .tx_fifo_rd_en(tx_fifo_rd_en), .tx_serial(tx_serial), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] data;
    int         div;
    bit         s2;
    bit         pe;
    bit         po;
  } frame_t;

  frame_t     exp_q[$];
  logic [7:0] fifo_q[$];
  int         rd_cycles[$];
  bit         mon_lv[$];
  int         checks = 0;
  int         passed = 0;
  int         cyc = 0;
  int         last_rd = -10;
  int         lvl_errs = 0;
  int         busy_errs = 0;
  bit         mon_active = 1'b0;
  bit         done_due = 1'b0;
  bit         pop_pend = 1'b0;

  task automatic chk(input bit ok, input string name, input longint act, input longint expv);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
  endtask

  function automatic void refresh();
    tx_fifo_empty = (fifo_q.size() == 0);
    tx_data = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  endfunction

  // Reference frame: each bit of the frame held for the clamped divisor.
  function automatic void load_levels(input frame_t f);
    int d;
    bit bits[$];
    d = (f.div < 2) ? 2 : f.div;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(f.data[i]);
    if (f.pe) bits.push_back((^f.data) ^ f.po);
    bits.push_back(1'b1);
    if (f.s2) bits.push_back(1'b1);
    mon_lv.delete();
    foreach (bits[i]) for (int k = 0; k < d; k++) mon_lv.push_back(bits[i]);
  endfunction

  function automatic bit cur_pe();
`ifdef UART_TX_PARITY_EN
    return parity_en;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit cur_po();
`ifdef UART_TX_PARITY_EN
    return parity_odd;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void push_exp(input logic [7:0] d);
    frame_t f;
    f.data = d;
    f.div  = int'(baud_div);
    f.s2   = stop2;
    f.pe   = cur_pe();
    f.po   = cur_po();
    exp_q.push_back(f);
  endfunction

  function automatic void push_byte(input logic [7:0] d, input bit with_exp);
    fifo_q.push_back(d);
    refresh();
    if (with_exp) push_exp(d);
  endfunction

  // FIFO model: a pop seen at negedge takes effect just after the loading edge.
  always @(posedge clock) begin
    #1;
    if (pop_pend) begin
      pop_pend = 1'b0;
      if (fifo_q.size() > 0) fifo_q.delete(0);
      refresh();
    end
  end

  // Monitor: pops one expected frame per start bit and checks it cycle by cycle.
  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      mon_active = 1'b0;
      done_due = 1'b0;
      mon_lv.delete();
    end else begin
      if (tx_fifo_rd_en) begin
        chk(!tx_fifo_empty && !tx_busy, "rd_en_legal", {tx_fifo_empty, tx_busy}, 0);
        last_rd = cyc;
        rd_cycles.push_back(cyc);
        pop_pend = 1'b1;
      end
      if (done_due) begin
        chk(tx_done && !tx_busy, "done_pulse", {tx_done, tx_busy}, 2);
        done_due = 1'b0;
      end else if (tx_done) begin
        chk(1'b0, "unexpected_done", 1, 0);
      end
      if (!mon_active && (tx_serial == 1'b0)) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_frame", 1, 0);
          mon_active = 1'b0;
        end else begin
          load_levels(exp_q.pop_front());
          mon_active = 1'b1;
          lvl_errs = 0;
          busy_errs = 0;
          chk(cyc == last_rd + 1, "start_latency", cyc - last_rd, 1);
        end
      end
      if (mon_active) begin
        if (tx_serial !== mon_lv[0]) lvl_errs++;
        if (tx_busy !== 1'b1) busy_errs++;
        mon_lv.delete(0);
        if (mon_lv.size() == 0) begin
          mon_active = 1'b0;
          done_due = 1'b1;
          chk(lvl_errs == 0, "frame_levels", lvl_errs, 0);
          chk(busy_errs == 0, "frame_busy", busy_errs, 0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (!(exp_q.size() == 0 && !mon_active && !done_due && !tx_busy) && n < budget) begin
      tick();
      n++;
    end
    chk(n < budget, name, n, budget);
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    while (!tx_busy && n < 50) begin
      tick();
      n++;
    end
    chk(tx_busy, name, n, 50);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt_rd, cnt_low, cnt_busy, bc, n;
    reset = 1'b1;
    tx_en = 1'b0;
    tick();
    @(negedge clock);
    chk(tx_serial == 1'b1, "reset_serial", tx_serial, 1);
    chk(tx_fifo_rd_en == 1'b0, "reset_rd_en", tx_fifo_rd_en, 0);
    chk(tx_busy == 1'b0, "reset_busy", tx_busy, 0);
    chk(tx_done == 1'b0, "reset_done", tx_done, 0);
    tick();
    reset = 1'b0;
    tick();

    // Single 0xA5 frame at div 4.
    baud_div = 16'd4;
    stop2 = 1'b0;
    tx_en = 1'b1;
    rd_cycles.delete();
    push_byte(8'hA5, 1'b1);
    drain("a5_drain", 200);
    chk(rd_cycles.size() == 1, "a5_rd_count", rd_cycles.size(), 1);

    // Back-to-back frames.
    rd_cycles.delete();
    push_byte(8'h55, 1'b1);
    push_byte(8'h0F, 1'b1);
    drain("b2b_drain", 300);
    chk(rd_cycles.size() == 2, "b2b_rd_count", rd_cycles.size(), 2);
    if (rd_cycles.size() == 2)
      chk(rd_cycles[1] - rd_cycles[0] == 41, "b2b_spacing", rd_cycles[1] - rd_cycles[0], 41);

    // Empty FIFO with tx_en held high.
    cnt_rd = 0; cnt_low = 0; cnt_busy = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (tx_fifo_rd_en) cnt_rd++;
      if (!tx_serial) cnt_low++;
      if (tx_busy) cnt_busy++;
    end
    chk(cnt_rd == 0, "empty_rd_en", cnt_rd, 0);
    chk(cnt_low == 0, "empty_line", cnt_low, 0);
    chk(cnt_busy == 0, "empty_busy", cnt_busy, 0);

    // tx_en dropped mid-frame: the frame completes, the next byte waits.
    rd_cycles.delete();
    push_byte(8'h3C, 1'b1);
    push_byte(8'h99, 1'b0);
    wait_busy("en_busy");
    tx_en = 1'b0;
    drain("en_drain", 200);
    repeat (60) tick();
    chk(rd_cycles.size() == 1, "en_rd_count", rd_cycles.size(), 1);
    chk(fifo_q.size() == 1, "en_fifo_left", fifo_q.size(), 1);
    push_exp(8'h99);
    tx_en = 1'b1;
    drain("en_resume", 200);

    // div 0 clamps to 2 with two stop bits; a mid-frame divisor change is ignored.
    stop2 = 1'b1;
    baud_div = 16'd0;
    push_byte(8'h81, 1'b1);
    wait_busy("s2_busy");
    baud_div = 16'd8;
    bc = 1;
    n = 0;
    while (n < 100) begin
      tick();
      n++;
      if (tx_busy) bc++;
      else n = 100;
    end
    chk(bc == 22, "s2_frame_len", bc, 22);
    drain("s2_drain", 100);
    stop2 = 1'b0;
    baud_div = 16'd4;

    // Reset during data bit 3.
    rd_cycles.delete();
    push_byte(8'hC3, 1'b1);
    n = 0;
    while (rd_cycles.size() == 0 && n < 50) begin
      tick();
      n++;
    end
    chk(rd_cycles.size() == 1, "rst_load", rd_cycles.size(), 1);
    repeat (17) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk(tx_serial == 1'b1, "rst_mid_serial", tx_serial, 1);
    chk(tx_busy == 1'b0, "rst_mid_busy", tx_busy, 0);
    chk(tx_done == 1'b0, "rst_mid_done", tx_done, 0);
    cnt_rd = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx_done) cnt_rd++;
    end
    chk(cnt_rd == 0, "rst_no_done", cnt_rd, 0);
    chk(rd_cycles.size() == 1, "rst_no_repop", rd_cycles.size(), 1);
    push_byte(8'h6E, 1'b1);
    drain("rst_recover", 200);

`ifdef UART_TX_PARITY_EN
    parity_en = 1'b1;
    parity_odd = 1'b0;
    push_byte(8'hA5, 1'b1);
    drain("par_even", 200);
    parity_odd = 1'b1;
    push_byte(8'hA5, 1'b1);
    drain("par_odd", 200);
    parity_en = 1'b0;
    parity_odd = 1'b0;
`endif

    // Randomized groups; configuration only changes while idle with the FIFO empty.
    for (int g = 0; g < 8; g++) begin
      baud_div = DIV_W'($urandom_range(0, 5));
      stop2 = 1'($urandom_range(0, 1));
`ifdef UART_TX_PARITY_EN
      parity_en = 1'($urandom_range(0, 1));
      parity_odd = 1'($urandom_range(0, 1));
`endif
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) push_byte(8'($urandom_range(0, 255)), 1'b1);
      drain("rand_drain", 1000);
    end
    chk(fifo_q.size() == 0, "final_fifo_empty", fifo_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
